// File: rtl/seq_shift_if.sv
// seq_shift_if: command and result handshakes for the iterative shifter.
interface seq_shift_if #(parameter int WIDTH = 8, parameter int SHAMT_W = 3);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_amt;
   logic               in_dir;
   logic [1:0]         in_mode;
   logic               ser_r;
   logic               ser_l;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_carry;
   logic               busy;
   modport master (
      output in_valid, in_data, in_amt, in_dir, in_mode, ser_r, ser_l, out_ready,
      input  in_ready, out_valid, out_data, out_carry, busy
   );
   modport slave (
      input  in_valid, in_data, in_amt, in_dir, in_mode, ser_r, ser_l, out_ready,
      output in_ready, out_valid, out_data, out_carry, busy
   );
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: one-bit-per-clock universal shifter with logical/arithmetic/rotate/serial fill.
module seq_shift_unit #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = 3
) (
   input logic       clk,
   input logic       rst,
   seq_shift_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t             state;
   logic [WIDTH-1:0]   data;
   logic [SHAMT_W-1:0] cnt;
   logic               dir;
   logic [1:0]         mode;
   logic               carry;
   logic               msb_fill;
   logic               lsb_fill;
   always_comb begin
      msb_fill = mode == 2'b00 ? 1'b0 :
                 mode == 2'b01 ? data[WIDTH-1] :
                 mode == 2'b10 ? data[0] : bus.ser_r;
      lsb_fill = mode == 2'b10 ? data[WIDTH-1] :
                 mode == 2'b11 ? bus.ser_l : 1'b0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         data  <= '0;
         cnt   <= '0;
         dir   <= 1'b0;
         mode  <= 2'b00;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               data  <= bus.in_data;
               cnt   <= bus.in_amt;
               dir   <= bus.in_dir;
               mode  <= bus.in_mode;
               carry <= 1'b0;
               state <= bus.in_amt == '0 ? DONE : SHIFT;
            end
            SHIFT: begin
               carry <= dir ? data[WIDTH-1] : data[0];
               data  <= dir ? {data[WIDTH-2:0], lsb_fill} : {msb_fill, data[WIDTH-1:1]};
               cnt   <= cnt - 1'b1;
               if (cnt == 1) state <= DONE;
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   assign bus.in_ready  = state == IDLE && !rst;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state != IDLE;
   assign bus.out_data  = data;
   assign bus.out_carry = carry;
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed vector table plus backpressure, serial-toggle and mid-shift reset sequences.
module tb_seq_shift_unit;
   localparam int W = 8;
   localparam int S = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   seq_shift_if #(.WIDTH(W), .SHAMT_W(S)) bus ();
   seq_shift_unit #(.WIDTH(W), .SHAMT_W(S)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   typedef struct {
      logic [W-1:0] data;
      logic [S-1:0] amt;
      logic         dir;
      logic [1:0]   mode;
      logic         sr;
      logic         sl;
      logic [W-1:0] exp_data;
      logic         exp_carry;
   } vec_t;
   vec_t vecs[10];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic wait_ready();
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
   endtask
   task automatic start(input logic [W-1:0] d, input logic [S-1:0] a, input logic dr, input logic [1:0] m);
      wait_ready();
      bus.in_data  = d;
      bus.in_amt   = a;
      bus.in_dir   = dr;
      bus.in_mode  = m;
      bus.in_valid = 1'b1;
   endtask
   task automatic run_vec(input vec_t v, input string name);
      int lat = 0;
      bus.ser_r = v.sr;
      bus.ser_l = v.sl;
      start(v.data, v.amt, v.dir, v.mode);
      do begin
         @(posedge clk);
         #1;
         lat++;
         bus.in_valid = 1'b0;
      end while (!bus.out_valid && lat < 50);
      check({name, "_latency"}, lat, 32'(v.amt) + 1);
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
      check({name, "_data"}, 32'(bus.out_data), 32'(v.exp_data));
      check({name, "_carry"}, 32'(bus.out_carry), 32'(v.exp_carry));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({name, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
      check({name, "_idle_hold"}, 32'(bus.out_data), 32'(v.exp_data));
   endtask
   initial begin
      vecs[0] = '{8'hB4, 4'd3, 1'b0, 2'b00, 1'b0, 1'b0, 8'h16, 1'b1};
      vecs[1] = '{8'hB4, 4'd2, 1'b0, 2'b01, 1'b0, 1'b0, 8'hED, 1'b0};
      vecs[2] = '{8'h81, 4'd1, 1'b1, 2'b10, 1'b0, 1'b0, 8'h03, 1'b1};
      vecs[3] = '{8'h00, 4'd4, 1'b0, 2'b11, 1'b1, 1'b0, 8'hF0, 1'b0};
      vecs[4] = '{8'h80, 4'd9, 1'b0, 2'b01, 1'b0, 1'b0, 8'hFF, 1'b1};
      vecs[5] = '{8'h80, 4'd9, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[6] = '{8'h5A, 4'd0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h5A, 1'b0};
      vecs[7] = '{8'h01, 4'd9, 1'b0, 2'b10, 1'b0, 1'b0, 8'h80, 1'b1};
      vecs[8] = '{8'hC3, 4'd2, 1'b1, 2'b01, 1'b0, 1'b0, 8'h0C, 1'b1};
      vecs[9] = '{8'h00, 4'd2, 1'b1, 2'b11, 1'b0, 1'b1, 8'h03, 1'b0};
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_amt = '0;
      bus.in_dir = 1'b0;
      bus.in_mode = 2'b00;
      bus.ser_r = 1'b0;
      bus.ser_l = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_carry", 32'(bus.out_carry), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
      // serial left with ser_l changing on every shift edge
      start(8'h00, 4'd3, 1'b1, 2'b11);
      bus.ser_l = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.ser_l = (i != 1);
         check($sformatf("ser_busy%0d", i), 32'(bus.busy), 32'd1);
         check($sformatf("ser_nvalid%0d", i), 32'(bus.out_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      check("ser_valid", 32'(bus.out_valid), 32'd1);
      check("ser_data", 32'(bus.out_data), 32'h05);
      check("ser_carry", 32'(bus.out_carry), 32'd0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      // amt 0 under long backpressure with an ignored in_valid pulse
      start(8'h5A, 4'd0, 1'b0, 2'b00);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i == 2);
         bus.in_data = 8'hFF;
         bus.in_amt = 4'd1;
         @(posedge clk);
         #1;
         check($sformatf("bp_data%0d", i), 32'(bus.out_data), 32'h5A);
         check($sformatf("bp_carry%0d", i), 32'(bus.out_carry), 32'd0);
         check($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
         check($sformatf("bp_out_valid%0d", i), 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("bp_release_ready", 32'(bus.in_ready), 32'd1);
      check("bp_release_valid", 32'(bus.out_valid), 32'd0);
      check("bp_release_data", 32'(bus.out_data), 32'h5A);
      // reset aborts a 6-step shift two cycles in
      start(8'h40, 4'd6, 1'b0, 2'b00);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_out_data", 32'(bus.out_data), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_recover_ready", 32'(bus.in_ready), 32'd1);
      run_vec('{8'h01, 4'd1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h02, 1'b0}, "after_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised, iterative universal shifter. Successor to the 4-bit one-step left/right shifter/mux datapath.
- Accepts a WIDTH-bit word plus a shift command over a valid/ready handshake.
- Shifts one bit position per clock for the requested amount, in any of four fill modes.
- Returns the result and the last bit shifted out over a second valid/ready handshake.
- Sits between the register-file read muxes and the writeback path of the course datapath.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
SHAMT_W, 3, width of the shift-amount field; amounts >= WIDTH are legal

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous, active-high reset
in_valid  input  1  command/data offered
in_ready  output  1  unit can accept a command
in_data  input  WIDTH  operand
in_amt  input  SHAMT_W  number of bit positions to shift
in_dir  input  1  0 = shift right (toward LSB), 1 = shift left
in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 serial fill
ser_r  input  1  fill bit entering MSB on right shifts in serial mode
ser_l  input  1  fill bit entering LSB on left shifts in serial mode
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result
out_carry  output  1  last bit shifted out
busy  output  1  high in SHIFT and DONE states

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; internal data and count 0; out_data = 0; out_carry = 0; out_valid = 0; busy = 0.
- in_ready is 0 while rst is high and 1 in IDLE otherwise.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE) && !rst. out_valid = (state == DONE). busy = (state != IDLE).
- IDLE:
  - On a clock edge with in_valid && in_ready: latch in_data, in_amt, in_dir and in_mode; clear carry.
  - Next state: DONE if in_amt == 0, else SHIFT.
  - Without in_valid: stay in IDLE.
- SHIFT: each edge performs one 1-bit step and decrements the count.
  - When the count equals 1 at the edge, go to DONE. The final step is applied on that same edge.
- Right step:
  - carry <= bit0.
  - Data shifts toward LSB.
  - New MSB = 0 (logical), old MSB (arithmetic), old bit0 (rotate), ser_r (serial).
- Left step:
  - carry <= MSB.
  - Data shifts toward MSB.
  - New LSB = 0 (logical and arithmetic), old MSB (rotate), ser_l (serial).
- ser_r / ser_l are sampled live on each SHIFT edge, not latched at accept.
- Latency: out_valid rises amt+1 edges after the accepting edge (amt = 0 gives 1 edge).
- Amounts >= WIDTH simply iterate:
  - logical gives 0;
  - arithmetic right gives all copies of the sign bit;
  - rotate wraps modulo WIDTH.
- DONE:
  - out_data and out_carry are held stable while out_valid && !out_ready. Unbounded backpressure is legal.
  - On an edge with out_ready high, go to IDLE.
  - out_data and out_carry keep their values in IDLE until the next accept.
- No overlap: in_valid is ignored outside IDLE, and a new command is accepted no earlier than the edge after the result handshake.
- amt = 0 result: data unchanged, carry 0.
- Reset asserted mid-operation: aborts immediately to reset values. No partial result is ever presented.

Test Plan:
- WIDTH=8. in_data=0xB4, amt=3, right, logical -> out_data=0x16, out_carry=1; out_valid exactly 4 edges after accept; busy high for those 4 cycles.
- 0xB4, amt=2, right, arithmetic -> out_data=0xED, out_carry=0. Then 0x81, amt=1, left, rotate -> out_data=0x03, out_carry=1.
- 0x00, amt=4, right, serial with ser_r held 1 -> 0xF0. 0x00, amt=3, left, serial with ser_l toggling 1,0,1 per SHIFT cycle -> 0x05.
- 0x5A, amt=0 -> out_valid 1 edge after accept, out_data=0x5A, out_carry=0. Hold out_ready=0 for 5 cycles: data stable, in_ready=0, a pulsed in_valid with 0xFF is ignored. Then out_ready=1 -> IDLE, in_ready=1.
- SHAMT_W=4, 0x80, amt=9, right, arithmetic -> 0xFF, carry=1. Same operand, logical -> 0x00, carry=0.
- Assert rst 2 cycles into a 6-step shift -> out_valid=0, out_data=0, busy=0 immediately. After deassert, in_ready=1 and a fresh 0x01, amt=1, left, logical completes with 0x02, carry=0.
